// File: rtl/dot_product_argmax_if.sv
// Handshake and result bundle between the sequencer and the argmax stage.
interface dot_product_argmax_if #(
  parameter int DATA_W = 26,
  parameter int IDX_W  = 4
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic              in_ready;
  logic              frame_clear;
  logic              out_valid;
  logic [IDX_W-1:0]  out_class;
  logic [DATA_W-1:0] out_score;
  logic [IDX_W-1:0]  count;
  logic              busy;

  modport master (
    output in_valid, in_data, frame_clear,
    input  in_ready, out_valid, out_class, out_score, count, busy
  );

  modport slave (
    input  in_valid, in_data, frame_clear,
    output in_ready, out_valid, out_class, out_score, count, busy
  );
endinterface

// File: rtl/dot_product_argmax.sv
// Running signed maximum over N_CLASSES dot-product results per frame;
// reports winning class index and score with a one-cycle strobe.
module dot_product_argmax #(
  parameter int DATA_W    = 26,
  parameter int N_CLASSES = 10,
  parameter int IDX_W     = 4
) (
  input logic                 clk,
  input logic                 GlobalReset,
  dot_product_argmax_if.slave bus
);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_CLASSES - 1);

  typedef enum logic [0:0] {ACC, DONE} state_t;

  state_t            state, state_nx;
  logic [IDX_W-1:0]  count_r;
  logic [DATA_W-1:0] best, best_nx;
  logic [IDX_W-1:0]  best_idx, best_idx_nx;
  logic [IDX_W-1:0]  out_class_r;
  logic [DATA_W-1:0] out_score_r;
  logic              accept;
  logic              last;
  logic              take;

  always_comb begin
    state_nx    = state;
    accept      = 1'b0;
    last        = (count_r == LAST_IDX);
    // First sample of a frame always seeds; later ones must strictly win so ties keep the lower index.
    take        = (count_r == '0) || ($signed(bus.in_data) > $signed(best));
    best_nx     = best;
    best_idx_nx = best_idx;
    if (take) begin
      best_nx     = bus.in_data;
      best_idx_nx = count_r;
    end
    unique case (state)
      ACC: begin
        if (bus.in_valid && !bus.frame_clear) begin
          accept = 1'b1;
          if (last) state_nx = DONE;
        end
      end
      DONE:    state_nx = ACC;
      default: state_nx = ACC;
    endcase
    if (bus.frame_clear) state_nx = ACC;
  end

  // Results are latched on the final accept edge, so the DONE cycle (and a frame_clear in it) only signals.
  always_ff @(posedge clk or negedge GlobalReset) begin
    if (!GlobalReset) begin
      state       <= ACC;
      count_r     <= '0;
      best        <= '0;
      best_idx    <= '0;
      out_class_r <= '0;
      out_score_r <= '0;
    end else begin
      state <= state_nx;
      if (bus.frame_clear) begin
        count_r <= '0;
      end else if (accept) begin
        best     <= best_nx;
        best_idx <= best_idx_nx;
        if (last) begin
          count_r     <= '0;
          out_class_r <= best_idx_nx;
          out_score_r <= best_nx;
        end else begin
          count_r <= count_r + 1'b1;
        end
      end
    end
  end

  assign bus.in_ready  = (state == ACC);
  assign bus.out_valid = (state == DONE);
  assign bus.out_class = out_class_r;
  assign bus.out_score = out_score_r;
  assign bus.count     = count_r;
  assign bus.busy      = (count_r != '0);

endmodule

// File: tb/tb_dot_product_argmax.sv
// Directed bench for dot_product_argmax with hand-computed expectations.
module tb_dot_product_argmax;
  logic clk;
  logic GlobalReset;
  int   checks = 0;
  int   errors = 0;

  dot_product_argmax_if #(.DATA_W(26), .IDX_W(4)) bus ();

  dot_product_argmax #(.DATA_W(26), .N_CLASSES(10), .IDX_W(4)) dut (
    .clk         (clk),
    .GlobalReset (GlobalReset),
    .bus         (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one sample, optionally followed by idle cycles; returns at edge+1.
  task automatic send(input logic [25:0] d, input int gap);
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    step();
    bus.in_valid = 1'b0;
    for (int g = 0; g < gap; g++) step();
  endtask

  logic [25:0] f [10];

  initial begin
    GlobalReset     = 1'b0;
    bus.in_valid    = 1'b1;
    bus.in_data     = 26'd5;
    bus.frame_clear = 1'b0;
    repeat (3) step();
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_count",     32'(bus.count),     32'd0);
    chk("rst_out_class", 32'(bus.out_class), 32'd0);
    chk("rst_out_score", 32'(bus.out_score), 32'd0);
    chk("rst_busy",      32'(bus.busy),      32'd0);
    #3;
    bus.in_valid = 1'b0;
    GlobalReset  = 1'b1;
    step();
    chk("rel_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rel_count",    32'(bus.count),    32'd0);

    // Ascending 1..10, contiguous
    for (int i = 1; i <= 10; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data  = 26'(i);
      step();
      if (i == 9) begin
        chk("asc_count9", 32'(bus.count), 32'd9);
        chk("asc_busy9",  32'(bus.busy),  32'd1);
        chk("asc_ov9",    32'(bus.out_valid), 32'd0);
      end
    end
    bus.in_data = 26'd77;
    chk("asc_out_valid", 32'(bus.out_valid), 32'd1);
    chk("asc_in_ready",  32'(bus.in_ready),  32'd0);
    chk("asc_out_class", 32'(bus.out_class), 32'd9);
    chk("asc_out_score", 32'(bus.out_score), 32'd10);
    chk("asc_count",     32'(bus.count),     32'd0);
    step();
    bus.in_valid = 1'b0;
    chk("asc_done_drop_count", 32'(bus.count),     32'd0);
    chk("asc_strobe_end",      32'(bus.out_valid), 32'd0);
    chk("asc_in_ready_back",   32'(bus.in_ready),  32'd1);
    chk("asc_hold_class",      32'(bus.out_class), 32'd9);

    // Negatives and ties
    f = '{26'(-5), 26'(-3), 26'd7, 26'd7, 26'(-100), 26'd0, 26'd2, 26'd7, 26'd1, 26'(-1)};
    for (int i = 0; i < 10; i++) send(f[i], 0);
    chk("neg_out_valid", 32'(bus.out_valid), 32'd1);
    chk("neg_out_class", 32'(bus.out_class), 32'd2);
    chk("neg_out_score", 32'(bus.out_score), 32'd7);
    step();

    // Signed extremes
    f = '{26'h2000000, 26'd0, 26'd0, 26'd0, 26'd0, 26'd0, 26'h1FFFFFF, 26'd0, 26'd0, 26'd0};
    for (int i = 0; i < 10; i++) send(f[i], 0);
    chk("ext_out_valid", 32'(bus.out_valid), 32'd1);
    chk("ext_out_class", 32'(bus.out_class), 32'd6);
    chk("ext_out_score", 32'(bus.out_score), 32'h1FFFFFF);
    step();

    // Mid-frame abort with a colliding sample
    send(26'd20, 0); send(26'd50, 0); send(26'd30, 0); send(26'd40, 0);
    chk("abt_count4", 32'(bus.count), 32'd4);
    bus.frame_clear = 1'b1;
    bus.in_valid    = 1'b1;
    bus.in_data     = 26'd99;
    step();
    bus.frame_clear = 1'b0;
    bus.in_valid    = 1'b0;
    chk("abt_count",     32'(bus.count),     32'd0);
    chk("abt_busy",      32'(bus.busy),      32'd0);
    chk("abt_out_valid", 32'(bus.out_valid), 32'd0);
    chk("abt_hold_class", 32'(bus.out_class), 32'd6);
    chk("abt_hold_score", 32'(bus.out_score), 32'h1FFFFFF);
    for (int i = 0; i < 9; i++) send(26'(10 - i), 0);
    chk("dsc_count9",     32'(bus.count),     32'd9);
    chk("dsc_hold_class", 32'(bus.out_class), 32'd6);
    send(26'd1, 0);
    chk("dsc_out_valid", 32'(bus.out_valid), 32'd1);
    chk("dsc_out_class", 32'(bus.out_class), 32'd0);
    chk("dsc_out_score", 32'(bus.out_score), 32'd10);
    step();

    // Gapped input, then frame_clear during the strobe cycle
    f = '{26'd3, 26'd8, 26'd1, 26'd8, 26'd2, 26'd9, 26'd9, 26'd0, 26'(-4), 26'd5};
    for (int i = 0; i < 9; i++) send(f[i], (i % 3) + 1);
    chk("gap_count9", 32'(bus.count), 32'd9);
    send(f[9], 0);
    bus.frame_clear = 1'b1;
    chk("gap_out_valid", 32'(bus.out_valid), 32'd1);
    chk("gap_out_class", 32'(bus.out_class), 32'd5);
    chk("gap_out_score", 32'(bus.out_score), 32'd9);
    step();
    bus.frame_clear = 1'b0;
    chk("gap_clr_ov",    32'(bus.out_valid), 32'd0);
    chk("gap_clr_ready", 32'(bus.in_ready),  32'd1);
    chk("gap_clr_class", 32'(bus.out_class), 32'd5);

    // Async reset at count=5
    for (int i = 0; i < 5; i++) send(26'(i + 100), 1);
    chk("ar_count5", 32'(bus.count), 32'd5);
    #2;
    GlobalReset = 1'b0;
    #1;
    chk("ar_count",     32'(bus.count),     32'd0);
    chk("ar_busy",      32'(bus.busy),      32'd0);
    chk("ar_out_class", 32'(bus.out_class), 32'd0);
    chk("ar_out_score", 32'(bus.out_score), 32'd0);
    #2;
    GlobalReset = 1'b1;
    step();
    step();
    chk("ar_out_valid", 32'(bus.out_valid), 32'd0);
    chk("ar_in_ready",  32'(bus.in_ready),  32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
